// File: rtl/c2h_st_sim_dsc_fifo.sv
// Elastic descriptor FIFO between the bypass router's simple-mode outputs and the QDMA C2H ST
// simple-bypass input. Order-preserving, flushable, with occupancy/high-water/forward counters.
module c2h_st_sim_dsc_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                       user_clk,
  input  logic                       user_reset,
  input  logic                       flush,

  input  logic [63:0]                in_addr,
  input  logic [10:0]                in_qid,
  input  logic                       in_error,
  input  logic [7:0]                 in_func,
  input  logic [2:0]                 in_port_id,
  input  logic                       in_vld,
  output logic                       in_rdy,

  output logic [63:0]                c2h_byp_in_st_sim_addr,
  output logic [10:0]                c2h_byp_in_st_sim_qid,
  output logic                       c2h_byp_in_st_sim_error,
  output logic [7:0]                 c2h_byp_in_st_sim_func,
  output logic [2:0]                 c2h_byp_in_st_sim_port_id,
  output logic                       c2h_byp_in_st_sim_vld,
  input  logic                       c2h_byp_in_st_sim_rdy,

  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     hwm,
  output logic [CNT_W-1:0]           fwd_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = 87;

  logic [PW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    hwm_q, hwm_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  logic             push, pop;
  logic [PW-1:0]    wr_data, rd_data;

  // Full blocks input even when a pop lands in the same cycle: no pass-through when full.
  assign in_rdy = ~user_reset & ~flush & (level_q < LW'(DEPTH));

  // Gated by reset so no output handshake can complete while the contents are being discarded.
  assign c2h_byp_in_st_sim_vld = ~user_reset & (level_q != '0);

  assign push = in_vld & in_rdy;
  assign pop  = c2h_byp_in_st_sim_vld & c2h_byp_in_st_sim_rdy;

  assign wr_data = {in_addr, in_qid, in_error, in_func, in_port_id};
  assign rd_data = mem_q[rd_ptr_q];

  assign {c2h_byp_in_st_sim_addr, c2h_byp_in_st_sim_qid, c2h_byp_in_st_sim_error,
          c2h_byp_in_st_sim_func, c2h_byp_in_st_sim_port_id} = rd_data;

  assign level   = level_q;
  assign hwm     = hwm_q;
  assign fwd_cnt = fwd_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    fwd_cnt_d = fwd_cnt_q + CNT_W'(pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A pop in the flush cycle is still a delivered descriptor, so fwd_cnt keeps it.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    if (flush) begin
      hwm_d = '0;
    end else if (level_d > hwm_q) begin
      hwm_d = level_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      hwm_q     <= '0;
      fwd_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      hwm_q     <= hwm_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_c2h_st_sim_dsc_fifo.sv
// Randomized scoreboard bench for c2h_st_sim_dsc_fifo: a queue model tracks accepted descriptors,
// and an independent negedge monitor checks outputs, occupancy, high-water mark and counter.
module tb_c2h_st_sim_dsc_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic              user_clk   = 1'b0;
  logic              user_reset = 1'b1;
  logic              flush      = 1'b0;
  logic [63:0]       in_addr    = '0;
  logic [10:0]       in_qid     = '0;
  logic              in_error   = 1'b0;
  logic [7:0]        in_func    = '0;
  logic [2:0]        in_port_id = '0;
  logic              in_vld     = 1'b0;
  logic              in_rdy;
  logic [63:0]       out_addr;
  logic [10:0]       out_qid;
  logic              out_error;
  logic [7:0]        out_func;
  logic [2:0]        out_port_id;
  logic              out_vld;
  logic              out_rdy    = 1'b0;
  logic [LW-1:0]     level;
  logic [LW-1:0]     hwm;
  logic [CNT_W-1:0]  fwd_cnt;

  c2h_st_sim_dsc_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .user_clk                  (user_clk),
    .user_reset                (user_reset),
    .flush                     (flush),
    .in_addr                   (in_addr),
    .in_qid                    (in_qid),
    .in_error                  (in_error),
    .in_func                   (in_func),
    .in_port_id                (in_port_id),
    .in_vld                    (in_vld),
    .in_rdy                    (in_rdy),
    .c2h_byp_in_st_sim_addr    (out_addr),
    .c2h_byp_in_st_sim_qid     (out_qid),
    .c2h_byp_in_st_sim_error   (out_error),
    .c2h_byp_in_st_sim_func    (out_func),
    .c2h_byp_in_st_sim_port_id (out_port_id),
    .c2h_byp_in_st_sim_vld     (out_vld),
    .c2h_byp_in_st_sim_rdy     (out_rdy),
    .level                     (level),
    .hwm                       (hwm),
    .fwd_cnt                   (fwd_cnt)
  );

  always #5 user_clk = ~user_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents of the FIFO after the most recent clock edge.
  logic [86:0]      exp_q[$];
  int unsigned      exp_hwm = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Driver bookkeeping for the edge that follows the inputs it just applied.
  bit          pend_push = 1'b0;
  bit          pend_clr  = 1'b0;
  logic [86:0] pend_data = '0;
  int          n_acc     = 0;
  int          desc_k    = 0;

  function automatic logic [86:0] rnd_desc(input bit err);
    logic [63:0] a;
    a = {$urandom, $urandom};
    return {a, 11'($urandom), err, 8'($urandom), 3'($urandom)};
  endfunction

  task automatic cyc(input bit v, input logic [86:0] d, input bit fl, input bit rs, input bit rd);
    @(posedge user_clk);
    #1;
    if (pend_clr) exp_q.delete();
    if (pend_push) exp_q.push_back(pend_data);
    in_vld = v;
    {in_addr, in_qid, in_error, in_func, in_port_id} = d;
    flush      = fl;
    user_reset = rs;
    out_rdy    = rd;
    #1;
    pend_push = in_vld && in_rdy;
    pend_data = d;
    pend_clr  = fl || rs;
    if (pend_push) n_acc++;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, rd);
  endtask

  task automatic push_rnd(input int n, input bit rd);
    for (int i = 0; i < n; i++) begin
      desc_k++;
      cyc(1'b1, rnd_desc(desc_k % 3 == 0), 1'b0, 1'b0, rd);
    end
  endtask

  // Monitor: compares DUT state against the model, then retires a descriptor on each handshake.
  bit          prev_stall = 1'b0;
  logic [86:0] prev_out   = '0;

  always @(negedge user_clk) begin
    logic [86:0] out_d;
    out_d = {out_addr, out_qid, out_error, out_func, out_port_id};
    if (user_reset) begin
      chk("rst_in_rdy", 128'(in_rdy), 128'(0));
      chk("rst_out_vld", 128'(out_vld), 128'(0));
      exp_cnt    = '0;
      exp_hwm    = 0;
      prev_stall = 1'b0;
    end else begin
      if (exp_q.size() > exp_hwm) exp_hwm = exp_q.size();
      chk("level", 128'(level), 128'(exp_q.size()));
      chk("hwm", 128'(hwm), 128'(exp_hwm));
      chk("fwd_cnt", 128'(fwd_cnt), 128'(exp_cnt));
      chk("out_vld", 128'(out_vld), 128'(exp_q.size() != 0));
      chk("in_rdy", 128'(in_rdy), 128'(!flush && exp_q.size() < DEPTH));
      if (prev_stall) begin
        chk("stall_vld", 128'(out_vld), 128'(1));
        chk("stall_data", 128'(out_d), 128'(prev_out));
      end
      if (out_vld && exp_q.size() != 0) begin
        chk("out_data", 128'(out_d), 128'(exp_q[0]));
      end
      if (out_vld && out_rdy && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      prev_stall = out_vld && !out_rdy && !flush;
      prev_out   = out_d;
      if (flush) exp_hwm = 0;
    end
  end

  initial begin
    logic [86:0] d0;
    int          acc0;

    repeat (3) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    d0 = {64'h1000_0000_0000_0040, 11'd5, 1'b0, 8'd1, 3'd2};
    cyc(1'b1, d0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("single_fwd_cnt", 128'(fwd_cnt), 128'(1));

    // Fill under backpressure: only DEPTH of 20 may be accepted.
    acc0 = n_acc;
    push_rnd(20, 1'b0);
    chk("fill_accepted", 128'(n_acc - acc0), 128'(DEPTH));
    idle(1, 1'b0);
    chk("fill_hwm", 128'(hwm), 128'(DEPTH));
    idle(DEPTH + 4, 1'b1);

    // Continuous streaming exercises many pointer wraps.
    push_rnd(1000, 1'b1);
    idle(3, 1'b1);

    // Random valid/ready with error on every third descriptor.
    for (int i = 0; i < 400; i++) begin
      desc_k++;
      cyc(($urandom % 4) != 0, rnd_desc(desc_k % 3 == 0), 1'b0, 1'b0, 1'($urandom));
    end
    idle(DEPTH + 4, 1'b1);

    // Flush with 7 queued and a coincident push that must be dropped.
    push_rnd(7, 1'b0);
    cyc(1'b1, rnd_desc(1'b0), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, rnd_desc(1'b1), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Flush coinciding with a pop: that pop still counts.
    push_rnd(4, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Reset with 5 queued, then a fresh descriptor.
    push_rnd(5, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, rnd_desc(1'b1), 1'b0, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("post_rst_fwd_cnt", 128'(fwd_cnt), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/c2h_st_sim_dsc_fifo.md
Name: c2h_st_sim_dsc_fifo

Overview:
- Elastic buffer between the C2H descriptor-bypass router's simple-mode outputs and the QDMA C2H ST simple-bypass input port (c2h_byp_in_st_sim_*).
- Decouples bursts of bypass-out descriptors from the QDMA's simple-bypass ready, so the router's c2h_byp_out_rdy is not stalled cycle-by-cycle.
- Preserves descriptor order, supports a synchronous flush on bypass-mode change, and exposes occupancy, high-water mark and a forwarded-descriptor counter for the perf register block.

Parameters:
- DEPTH, 16: FIFO entries; power of 2, range 2..256.
- CNT_W, 32: width of the forwarded-descriptor counter.

Ports:
- user_clk  in  1  clock
- user_reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous FIFO clear (one-cycle pulse, driven on bypass-mode change)
- in_addr  in  64  descriptor address from router
- in_qid  in  11  queue id
- in_error  in  1  descriptor error flag
- in_func  in  8  function
- in_port_id  in  3  port id
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- c2h_byp_in_st_sim_addr  out  64  to QDMA
- c2h_byp_in_st_sim_qid  out  11  to QDMA
- c2h_byp_in_st_sim_error  out  1  to QDMA
- c2h_byp_in_st_sim_func  out  8  to QDMA
- c2h_byp_in_st_sim_port_id  out  3  to QDMA
- c2h_byp_in_st_sim_vld  out  1  output valid
- c2h_byp_in_st_sim_rdy  in  1  QDMA ready
- level  out  $clog2(DEPTH)+1  current occupancy
- hwm  out  $clog2(DEPTH)+1  maximum occupancy since reset/flush
- fwd_cnt  out  CNT_W  descriptors accepted by QDMA since reset

Behaviour:
- Clock/reset: single clock user_clk; user_reset synchronous, active-high.
- Reset values: rd/wr pointers 0, level 0, hwm 0, fwd_cnt 0, c2h_byp_in_st_sim_vld 0, in_rdy 0 during reset and 1 in the first cycle after reset deasserts.
- Payload: 87 bits {addr, qid, error, func, port_id}, all fields passed through unmodified; error descriptors are forwarded, never dropped.
- Push: in_vld & in_rdy. in_rdy = ~user_reset & ~flush & (level < DEPTH), registered-free combinational from the level register.
- Pop: c2h_byp_in_st_sim_vld & c2h_byp_in_st_sim_rdy. Output valid = (level != 0); output data driven from the storage entry at rd_ptr.
- Output holds stable while vld=1 and rdy=0 (AXI-style; no data change, no vld drop).
- Latency: a descriptor pushed into an empty FIFO in cycle N is valid at the output in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop: level unchanged, both pointers advance.
- When full, in_rdy=0 even if a pop occurs in the same cycle (no pass-through when full).
- Pointers: $clog2(DEPTH) bits and wrap naturally; level is tracked separately to distinguish full from empty.
- hwm: updated each cycle to max(hwm, next level).
- fwd_cnt: +1 per pop; wraps modulo 2^CNT_W.
- flush:
  - Next cycle: pointers 0, level 0, hwm 0, output vld 0.
  - A push coinciding with flush is discarded (in_rdy=0 during flush).
  - A pop coinciding with flush still counts in fwd_cnt.
  - fwd_cnt is not cleared by flush.
- Reset mid-operation: all contents discarded, no output handshake completes in the reset cycle.
- Storage may be inferred as distributed RAM; there is no read latency beyond the registered pointer.

Test Plan:
- Single descriptor: after reset, push addr=0x1000_0000_0000_0040, qid=5, func=1, port_id=2 in cycle 3 with rdy=1 -> vld in cycle 4 with identical fields, fwd_cnt=1, level returns to 0.
- Fill/backpressure with DEPTH=16, rdy=0: push 20 descriptors -> exactly 16 accepted, in_rdy=0 from the cycle level=16, hwm=16. Then raise rdy -> 16 outputs in push order, one per cycle.
- Streaming: in_vld=1 and rdy=1 continuously for 1000 cycles -> level stays at or below 1, fwd_cnt=999 or 1000 depending on start alignment, no reordering. Wrap checked over 62 pointer rollovers.
- Stall stability: rdy toggles 1/0 randomly with error=1 on every 3rd descriptor -> output fields constant while vld & ~rdy, and error bits delivered on the same descriptors they arrived on.
- Flush: 7 entries queued, pulse flush alongside in_vld -> next cycle level=0, vld=0, hwm=0, that push is dropped, fwd_cnt unchanged. The next push emerges one cycle later.
- Mid-stream reset: assert user_reset with 5 entries queued -> next cycle vld=0, level=0, fwd_cnt=0. After deassert, the first new descriptor is output correctly.
